// File: rtl/spi_bank_pkg.sv
// spi_bank_pkg -- shared definitions for the serial channel register bank.
//   state_t      : frame FSM states (ST_PAR exists only when
//                  SPI_BANK_PARITY_EN is defined)
//   RW_BIT_OFS   : position of the R/W flag counted from the MSB of the
//                  command word (it is the first bit shifted in)
//   even_parity  : XOR reduction used for the optional data parity bit
package spi_bank_pkg;

`ifdef SPI_BANK_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DATA, ST_PAR, ST_DONE} state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_t;
`endif

   localparam int RW_BIT_OFS = 0;

   function automatic logic even_parity(input logic [63:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/spi_chan_bank_if.sv
// spi_chan_bank_if -- serial programming port plus parallel channel outputs.
//   sel, serial_in          : frame enable and serial data (master -> bank)
//   serial_out              : read-back data (bank -> master)
//   ch, wr_strobe, busy, err: channel registers and status (bank -> master)
interface spi_chan_bank_if #(
   parameter int NUM_CH = 8,
   parameter int CH_W   = 8
);
   logic                     sel;
   logic                     serial_in;
   logic                     serial_out;
   logic [NUM_CH*CH_W-1:0]   ch;
   logic [NUM_CH-1:0]        wr_strobe;
   logic                     busy;
   logic                     err;

   modport master (output sel, serial_in,
                   input  serial_out, ch, wr_strobe, busy, err);
   modport slave  (input  sel, serial_in,
                   output serial_out, ch, wr_strobe, busy, err);
endinterface

// File: rtl/spi_shifter.sv
// spi_shifter -- W-bit shift register, MSB first, with parallel load.
//   sclk, rst  : clock, synchronous active-high reset
//   load       : capture load_data (read snapshot); has priority over shift
//   shift      : shift left, serial_in enters at bit 0
//   data       : register contents; data[W-1] is the serial output bit
// W must be at least 2.
module spi_shifter #(
   parameter int W = 8
) (
   input  logic         sclk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic         serial_in,
   input  logic [W-1:0] load_data,
   output logic [W-1:0] data
);
   logic [W-1:0] data_reg;

   always_ff @(posedge sclk) begin
      if (rst)
         data_reg <= '0;
      else if (load)
         data_reg <= load_data;
      else if (shift)
         data_reg <= {data_reg[W-2:0], serial_in};
   end

   assign data = data_reg;
endmodule

// File: rtl/spi_chan_bank.sv
// spi_chan_bank -- addressed serial read/write bank of NUM_CH x CH_W registers.
//   sclk, rst : the only clock; synchronous active-high reset
//   bus       : spi_chan_bank_if slave port (sel, serial_in, serial_out,
//               ch, wr_strobe, busy, err)
// Frame: R/W bit, ADDR_W address bits, CH_W data bits, all MSB first. A
// write commits one edge after its last data bit; sel must still be high.
// Optional feature macro: SPI_BANK_PARITY_EN adds an even-parity bit after
// the data (checked on writes, driven on reads).
module spi_chan_bank
   import spi_bank_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int CH_W   = 8,
   parameter int ADDR_W = 7
) (
   input logic             sclk,
   input logic             rst,
   spi_chan_bank_if.slave  bus
);
   localparam int CMD_W   = ADDR_W + 1;
   localparam int RW_POS  = CMD_W - 1 - RW_BIT_OFS;
   localparam int CNT_MAX = (CMD_W > CH_W) ? CMD_W : CH_W;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [CMD_W-1:0]       cmd_reg;
   logic [CMD_W-1:0]       cmd_now;
   logic [ADDR_W-1:0]      addr_now, addr;
   logic                   rw, in_range;
   logic [CH_W-1:0]        snap, sh_data;
   logic [NUM_CH*CH_W-1:0] ch_flat;
   logic [NUM_CH-1:0]      strobe_vec;
   logic                   sh_load, sh_shift, commit, par_bad, do_write;
   logic                   err_reg, so;
`ifdef SPI_BANK_PARITY_EN
   logic                   capture_par, par_bit_reg, rd_par_reg;
`endif

   // Command word including the bit sampled on the current edge; on the
   // last command edge this is the complete word used for the snapshot.
   assign cmd_now  = {cmd_reg[CMD_W-2:0], bus.serial_in};
   assign addr_now = cmd_now[ADDR_W-1:0];
   assign addr     = cmd_reg[ADDR_W-1:0];
   assign rw       = cmd_reg[RW_POS];
   assign in_range = ({1'b0, addr} < (ADDR_W+1)'(NUM_CH));

   // Out-of-range addresses match no channel, so reads return zeros.
   always_comb begin
      snap = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (addr_now == ADDR_W'(k))
            snap = ch_flat[k*CH_W +: CH_W];
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // In DATA, cnt counts received bits; cnt == CH_W marks the edge after
   // the last data bit, which is where the frame completes.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sh_load    = 1'b0;
      sh_shift   = 1'b0;
      commit     = 1'b0;
`ifdef SPI_BANK_PARITY_EN
      capture_par = 1'b0;
`endif
      if (!bus.sel) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next = ST_CMD;
               cnt_next   = CNT_W'(1);
            end
            ST_CMD: begin
               if (cnt_reg == CNT_W'(CMD_W-1)) begin
                  state_next = ST_DATA;
                  cnt_next   = '0;
                  sh_load    = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (cnt_reg == CNT_W'(CH_W)) begin
`ifdef SPI_BANK_PARITY_EN
                  state_next  = ST_PAR;
                  capture_par = 1'b1;
`else
                  state_next = ST_DONE;
                  commit     = 1'b1;
`endif
               end else begin
                  sh_shift = 1'b1;
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
`ifdef SPI_BANK_PARITY_EN
            ST_PAR: begin
               state_next = ST_DONE;
               commit     = 1'b1;
            end
`endif
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // One register serves both directions: write data shifts in, the read
   // snapshot shifts out of the MSB.
   spi_shifter #(.W(CH_W)) u_shifter (
      .sclk      (sclk),
      .rst       (rst),
      .load      (sh_load),
      .shift     (sh_shift),
      .serial_in (bus.serial_in),
      .load_data (snap),
      .data      (sh_data)
   );

`ifdef SPI_BANK_PARITY_EN
   assign par_bad = !rw && (par_bit_reg != even_parity(64'(sh_data)));
`else
   assign par_bad = 1'b0;
`endif
   assign do_write = commit && in_range && !rw && !par_bad;

   always_ff @(posedge sclk) begin
      if (rst) begin
         cmd_reg <= '0;
         err_reg <= 1'b0;
`ifdef SPI_BANK_PARITY_EN
         par_bit_reg <= 1'b0;
         rd_par_reg  <= 1'b0;
`endif
      end else begin
         if (bus.sel && (state_reg == ST_IDLE || state_reg == ST_CMD))
            cmd_reg <= cmd_now;
         if (commit && (!in_range || par_bad))
            err_reg <= 1'b1;
`ifdef SPI_BANK_PARITY_EN
         if (capture_par)
            par_bit_reg <= bus.serial_in;
         if (sh_load)
            rd_par_reg <= even_parity(64'(snap));
`endif
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CH_W-1:0] ch_reg;
         logic            strobe_reg;
         logic            hit;
         assign hit = do_write && (addr == ADDR_W'(gi));
         always_ff @(posedge sclk) begin
            if (rst) begin
               ch_reg     <= '0;
               strobe_reg <= 1'b0;
            end else begin
               strobe_reg <= hit;
               if (hit)
                  ch_reg <= sh_data;
            end
         end
         assign ch_flat[gi*CH_W +: CH_W] = ch_reg;
         assign strobe_vec[gi]           = strobe_reg;
      end
   endgenerate

   // Read data is live only in DATA; the cycle after the last data bit
   // carries the snapshot parity when parity is enabled, else zero.
   always_comb begin
      so = 1'b0;
      if (state_reg == ST_DATA && rw) begin
         if (cnt_reg < CNT_W'(CH_W))
            so = sh_data[CH_W-1];
`ifdef SPI_BANK_PARITY_EN
         else
            so = rd_par_reg;
`endif
      end
   end

   assign bus.serial_out = so;
   assign bus.ch         = ch_flat;
   assign bus.wr_strobe  = strobe_vec;
   assign bus.busy       = (state_reg != ST_IDLE);
   assign bus.err        = err_reg;
endmodule

// File: tb/tb_spi_chan_bank.sv
module tb_spi_chan_bank;
   localparam int NUM_CH = 8;
   localparam int CH_W   = 8;
   localparam int ADDR_W = 7;
   localparam int CMD_W  = ADDR_W + 1;
`ifdef SPI_BANK_PARITY_EN
   localparam int PAR_N  = 1;
`else
   localparam int PAR_N  = 0;
`endif
   // Commit edge index: one edge after the last data (or parity) bit.
   localparam int CE = CMD_W + CH_W + PAR_N;

   typedef struct {
      bit        rw;
      bit [6:0]  addr;
      bit [7:0]  data;
      bit [7:0]  exp_rd;
      bit [7:0]  exp_strobe;
      bit        exp_err;
   } vec_t;

   logic sclk = 1'b0;
   logic rst;
   always #5 sclk = ~sclk;

   spi_chan_bank_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

   spi_chan_bank #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W)) dut (
      .sclk (sclk),
      .rst  (rst),
      .bus  (bus)
   );

   int       tests  = 0;
   int       failed = 0;
   bit [7:0] exp_ch [NUM_CH];
   bit       rd_q [$];
   vec_t     vecs [9];
   int       sc, sk;
   logic [7:0] sv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_flat();
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < NUM_CH; k++)
         r[k*CH_W +: CH_W] = exp_ch[k];
      return r;
   endfunction

   // Drives one frame (plus one padding edge in DONE), scoring read-back
   // bits from the queue and recording every wr_strobe pulse seen.
   task automatic run_frame(input bit rw, input bit [6:0] addr, input bit [7:0] data,
                            input bit par_bit, input int cut_at, input bit [7:0] exp_rd,
                            output int stb_cnt, output int stb_k, output logic [7:0] stb_val);
      bit stream [CE+2];
      int ai;
      ai = int'(addr);
      for (int i = 0; i < CE+2; i++) stream[i] = 1'b0;
      stream[0] = rw;
      for (int i = 0; i < ADDR_W; i++) stream[1+i] = addr[ADDR_W-1-i];
      for (int i = 0; i < CH_W; i++) stream[CMD_W+i] = data[CH_W-1-i];
`ifdef SPI_BANK_PARITY_EN
      stream[CMD_W+CH_W] = par_bit;
`else
      if (par_bit) stream[CE+1] = 1'b1;   // bit sent while in DONE; must be ignored
`endif
      stb_cnt = 0;
      stb_k   = -1;
      stb_val = '0;
      rd_q.delete();
      if (rw) begin
         for (int i = 0; i < CH_W; i++) rd_q.push_back(exp_rd[CH_W-1-i]);
`ifdef SPI_BANK_PARITY_EN
         rd_q.push_back(^exp_rd);
`endif
      end
      for (int k = 0; k < CE+2; k++) begin
         @(negedge sclk);
         if (bus.wr_strobe != '0) begin
            stb_cnt++;
            stb_k   = k;
            stb_val = bus.wr_strobe;
         end
         if (k == cut_at) break;
         if (rw && k >= CMD_W && k < CMD_W + CH_W + PAR_N) begin
            if (rd_q.size() == 0)
               chk("rd_queue_empty", 64'(1), 64'(0));
            else
               chk($sformatf("serial_out_cycle%0d", k), 64'(bus.serial_out), 64'(rd_q.pop_front()));
         end else begin
            chk($sformatf("serial_out_zero_cycle%0d", k), 64'(bus.serial_out), 64'(0));
         end
         if (k == CE && ai < NUM_CH)
            chk("ch_before_commit", 64'(bus.ch[ai*CH_W +: CH_W]), 64'(exp_ch[ai]));
         bus.sel       = 1'b1;
         bus.serial_in = stream[k];
      end
      if (cut_at < 0) begin
         @(negedge sclk);
         if (bus.wr_strobe != '0) begin stb_cnt++; stb_k = CE+2; stb_val = bus.wr_strobe; end
      end
      bus.sel       = 1'b0;
      bus.serial_in = 1'b0;
      @(negedge sclk);
      if (bus.wr_strobe != '0) begin stb_cnt++; stb_k = CE+3; stb_val = bus.wr_strobe; end
      chk("busy_after_sel_low", 64'(bus.busy), 64'(0));
      rd_q.delete();
   endtask

   task automatic score_frame(input string tag, input bit [7:0] exp_strobe, input bit exp_err);
      chk({tag, "_strobe_count"}, 64'(sc), 64'((exp_strobe != 0) ? 1 : 0));
      chk({tag, "_strobe_value"}, 64'(sv), 64'(exp_strobe));
      if (exp_strobe != 0) chk({tag, "_strobe_cycle"}, 64'(sk), 64'(CE+1));
      chk({tag, "_err"}, 64'(bus.err), 64'(exp_err));
      chk({tag, "_ch_all"}, 64'(bus.ch), model_flat());
      $display("[TB] %s: strobes=%0d strobe=0x%02h err=%0d ch=0x%016h",
               tag, sc, sv, bus.err, bus.ch);
   endtask

   initial begin
      //          rw    addr   data   exp_rd exp_strobe err
      vecs[0] = '{1'b0, 7'h03, 8'hA5, 8'h00, 8'h08, 1'b0};
      vecs[1] = '{1'b1, 7'h03, 8'h00, 8'hA5, 8'h00, 1'b0};
      vecs[2] = '{1'b0, 7'h00, 8'h3C, 8'h00, 8'h01, 1'b0};
      vecs[3] = '{1'b0, 7'h07, 8'h81, 8'h00, 8'h80, 1'b0};
      vecs[4] = '{1'b1, 7'h00, 8'hFF, 8'h3C, 8'h00, 1'b0};
      vecs[5] = '{1'b1, 7'h07, 8'h00, 8'h81, 8'h00, 1'b0};
      vecs[6] = '{1'b1, 7'h05, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[7] = '{1'b0, 7'h03, 8'h5A, 8'h00, 8'h08, 1'b0};
      vecs[8] = '{1'b1, 7'h03, 8'h00, 8'h5A, 8'h00, 1'b0};
      for (int k = 0; k < NUM_CH; k++) exp_ch[k] = 8'h00;

      bus.sel       = 1'b0;
      bus.serial_in = 1'b0;
      rst           = 1'b1;
      repeat (2) @(negedge sclk);
      chk("reset_ch", 64'(bus.ch), 64'(0));
      chk("reset_serial_out", 64'(bus.serial_out), 64'(0));
      chk("reset_wr_strobe", 64'(bus.wr_strobe), 64'(0));
      chk("reset_busy", 64'(bus.busy), 64'(0));
      chk("reset_err", 64'(bus.err), 64'(0));
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_frame(vecs[i].rw, vecs[i].addr, vecs[i].data, ^vecs[i].data, -1,
                   vecs[i].exp_rd, sc, sk, sv);
         if (vecs[i].exp_strobe != 0) exp_ch[int'(vecs[i].addr)] = vecs[i].data;
         score_frame($sformatf("vec%0d", i), vecs[i].exp_strobe, vecs[i].exp_err);
      end

      // Abort after 12 bits of a write to ch5.
      run_frame(1'b0, 7'h05, 8'h5A, ^8'h5A, 12, 8'h00, sc, sk, sv);
      score_frame("abort_ch5", 8'h00, 1'b0);

      // Out-of-range write sets sticky err; later valid frames keep it.
      run_frame(1'b0, 7'h0A, 8'hFF, ^8'hFF, -1, 8'h00, sc, sk, sv);
      score_frame("oor_write", 8'h00, 1'b1);
      run_frame(1'b0, 7'h02, 8'h11, ^8'h11, -1, 8'h00, sc, sk, sv);
      exp_ch[2] = 8'h11;
      score_frame("write_ch2_err_sticky", 8'h04, 1'b1);
      run_frame(1'b1, 7'h0A, 8'h00, 1'b0, -1, 8'h00, sc, sk, sv);
      score_frame("oor_read", 8'h00, 1'b1);

      // Reset in cycle 10 of a read of ch3.
      for (int k = 0; k <= 10; k++) begin
         @(negedge sclk);
         if (k == 10) begin
            chk("rd_before_rst", 64'(bus.serial_out), 64'(exp_ch[3][CH_W-1-(k-CMD_W)]));
            rst = 1'b1;
         end
         bus.sel       = 1'b1;
         bus.serial_in = (k == 0 || k == 6 || k == 7) ? 1'b1 : 1'b0;   // 0x83
      end
      @(negedge sclk);
      for (int k = 0; k < NUM_CH; k++) exp_ch[k] = 8'h00;
      chk("rst_mid_serial_out", 64'(bus.serial_out), 64'(0));
      chk("rst_mid_ch", 64'(bus.ch), 64'(0));
      chk("rst_mid_busy", 64'(bus.busy), 64'(0));
      chk("rst_mid_err", 64'(bus.err), 64'(0));
      rst = 1'b0;
      @(negedge sclk);
      chk("new_frame_after_rst_busy", 64'(bus.busy), 64'(1));
      bus.sel = 1'b0;
      @(negedge sclk);
      $display("[TB] rst_mid_read: serial_out=%0d busy=%0d err=%0d", bus.serial_out, bus.busy, bus.err);

`ifdef SPI_BANK_PARITY_EN
      run_frame(1'b0, 7'h01, 8'h07, 1'b0, -1, 8'h00, sc, sk, sv);
      score_frame("par_bad_ch1", 8'h00, 1'b1);
      rst = 1'b1;
      @(negedge sclk);
      rst = 1'b0;
      chk("par_rst_err", 64'(bus.err), 64'(0));
      run_frame(1'b0, 7'h01, 8'h07, 1'b1, -1, 8'h00, sc, sk, sv);
      exp_ch[1] = 8'h07;
      score_frame("par_good_ch1", 8'h02, 1'b0);
`else
      run_frame(1'b0, 7'h01, 8'h07, 1'b1, -1, 8'h00, sc, sk, sv);
      exp_ch[1] = 8'h07;
      score_frame("write_ch1_done_bit", 8'h02, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
